data_wrsm: RTL and testbench

DATA_WRSM -- requirements
Module: data_wrsm

---
 rtl/data_wrsm.sv | 91 +++++++++
 tb/tb_data_wrsm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_wrsm.sv
// Two-entry in-order write buffer between an upstream valid/ready source and a FIFO write port.
// data_ready depends only on registered occupancy, so upstream sees no combinational path from Wfull.
module data_wrsm #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic          flush,
  input  logic          Wfull,
  output logic          Winc,
  output logic [DW-1:0] Wdata,
  output logic [15:0]   wr_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          accept, write;

  assign data_ready = (state_q != TWO);
  assign Winc       = (state_q != EMPTY) && !Wfull;
  assign accept     = data_valid && data_ready;
  assign write      = Winc;
  // head_q is left untouched on entry to EMPTY, so it already holds the last presented word
  assign Wdata      = head_q;
  assign wr_count   = cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q + {15'd0, write};
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = data_in;
        end
      end
      ONE: begin
        unique case ({accept, write})
          2'b10: begin
            state_d = TWO;
            tail_d  = data_in;
          end
          2'b01: state_d = EMPTY;
          2'b11: head_d  = data_in;
          default: ;
        endcase
      end
      TWO: begin
        if (write) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any word offered this cycle but keeps Wdata stable
    if (flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      tail_d  = tail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_wrsm.sv
// Scoreboard bench for data_wrsm: accepted words queued, compared against each FIFO write.
module tb_data_wrsm;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          flush;
  logic          Wfull;
  logic          Winc;
  logic [DW-1:0] Wdata;
  logic [15:0]   wr_count;

  data_wrsm #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .flush      (flush),
    .Wfull      (Wfull),
    .Winc       (Winc),
    .Wdata      (Wdata),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] sb_q[$];
  logic [15:0]   exp_cnt  = '0;
  logic [DW-1:0] exp_hold = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive just after posedge, sample at negedge, check count after next posedge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic f,
                      input logic fl, input logic r);
    logic exp_rdy, exp_winc;
    data_valid = v;
    data_in    = d;
    Wfull      = f;
    flush      = fl;
    rst        = r;
    @(negedge clk);
    exp_rdy  = (sb_q.size() < 2);
    exp_winc = (sb_q.size() > 0) && !f;
    chk("ready", data_ready, exp_rdy);
    chk("winc", Winc, exp_winc);
    if (sb_q.size() > 0) begin
      exp_hold = sb_q[0];
      chk("wdata", Wdata, sb_q[0]);
    end else begin
      chk("wdata_hold", Wdata, exp_hold);
    end
    if (exp_winc) begin
      void'(sb_q.pop_front());
      exp_cnt++;
    end
    if (r) begin
      sb_q.delete();
      exp_cnt  = '0;
      exp_hold = '0;
    end else if (fl) begin
      sb_q.delete();
    end else if (v && exp_rdy) begin
      sb_q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("wr_count", wr_count, exp_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; flush = 1'b0; Wfull = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_winc", Winc, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst_wdata", Wdata, 0);
    chk("rst_cnt", wr_count, 0);

    // single word, 1-cycle latency
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    chk("lat_winc", Winc, 1);
    chk("lat_wdata", Wdata, 16'h1234);
    idle(1);
    chk("lat_cnt", wr_count, 1);

    // backpressure fills both entries, third word held
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hA001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hA002, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hA003, 1'b1, 1'b0, 1'b0);
      chk("bp_ready_low", data_ready, 0);
    end
    step(1'b1, 16'hA003, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hA003, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("bp_cnt", wr_count, 3);
    chk("bp_last", Wdata, 16'hA003);

    // 256-word stream at full rate
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("stream_cnt", wr_count, 256);

    // flush while TWO and full, then a fresh word is next out
    step(1'b1, 16'hB001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hB002, 1'b1, 1'b0, 1'b0);
    chk("fl_two", data_ready, 0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
    chk("fl_empty_winc", Winc, 0);
    chk("fl_empty_ready", data_ready, 1);
    step(1'b1, 16'hC000, 1'b0, 1'b0, 1'b0);
    chk("fl_next", Wdata, 16'hC000);
    chk("fl_next_winc", Winc, 1);
    idle(2);
    chk("fl_cnt", wr_count, 257);

    // reset mid-burst
    for (int i = 0; i < 4; i++) step(1'b1, 16'h5500 + 16'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h55FF, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_winc", Winc, 0);
    chk("mid_rst_wdata", Wdata, 0);
    idle(2);

    // counter wrap
    for (int i = 0; i < 65535; i++) step(1'b1, 16'(i * 7), 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("wrap_ffff", wr_count, 16'hFFFF);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("wrap_zero", wr_count, 16'h0000);

    // random valid / full / occasional flush
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rand_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
